// File: rtl/usb_rx_timer.sv
// USB receive bit-timing controller: resynchronises a per-bit clock counter on line edges,
// strobes the shift register once per bit, pulses on byte completion and flags a dead line.
module usb_rx_timer #(
    parameter int CLKS_PER_BIT  = 8,
    parameter int SAMPLE_POINT  = 3,
    parameter int BITS_PER_BYTE = 8,
    parameter int MAX_IDLE_BITS = 7
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             enable_timer,
    input  logic                             d_edge,
    input  logic                             stuff_bit,
    output logic                             shift_enable,
    output logic                             byte_received,
    output logic [$clog2(BITS_PER_BYTE)-1:0] bit_count,
    output logic                             rx_error,
    output logic                             state_dbg
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int BC_W   = $clog2(BITS_PER_BYTE);
    localparam int IDLE_W = $clog2(MAX_IDLE_BITS + 1);

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_SAMPLE = CNT_W'(SAMPLE_POINT);
    localparam logic [BC_W-1:0]   BC_LAST    = BC_W'(BITS_PER_BYTE - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(MAX_IDLE_BITS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [CNT_W-1:0]    clk_cnt;
    logic [IDLE_W-1:0]   idle_cnt;
    logic                active;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: both states simply follow enable_timer
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable_timer)  next_state = RUN;
            RUN:     if (!enable_timer) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        active       = (state == RUN) && enable_timer;
        shift_enable = active && (clk_cnt == CNT_SAMPLE) && !stuff_bit;
        state_dbg    = state;
    end

    // Counters; anything other than an enabled RUN cycle clears the bit-timing context.
    // byte_received is outside that gate so a byte completing as enable falls still reports.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt       <= '0;
            bit_count     <= '0;
            idle_cnt      <= '0;
            byte_received <= 1'b0;
            rx_error      <= 1'b0;
        end else begin
            byte_received <= shift_enable && (bit_count == BC_LAST);
            if (active) begin
                if (d_edge || (clk_cnt == CNT_LAST)) begin
                    clk_cnt <= '0;
                end else begin
                    clk_cnt <= clk_cnt + 1'b1;
                end

                if (shift_enable) begin
                    bit_count <= (bit_count == BC_LAST) ? '0 : bit_count + 1'b1;
                end

                if (d_edge) begin
                    idle_cnt <= '0;
                end else if ((clk_cnt == CNT_LAST) && (idle_cnt != IDLE_MAX)) begin
                    idle_cnt <= idle_cnt + 1'b1;
                end

                if (idle_cnt == IDLE_MAX) begin
                    rx_error <= 1'b1;
                end
            end else begin
                clk_cnt   <= '0;
                bit_count <= '0;
                idle_cnt  <= '0;
                rx_error  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_timer.sv
// Directed bench for usb_rx_timer: expected strobe and byte cycles are queued as stimulus
// is planned and retired by negedge monitors as the DUT produces them.
module tb_usb_rx_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable_timer;
    logic       d_edge;
    logic       stuff_bit;
    logic       shift_enable;
    logic       byte_received;
    logic [2:0] bit_count;
    logic       rx_error;
    logic       state_dbg;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [31:0] exp_q[$];
    logic [2:0]  exp_bc_q[$];
    logic [31:0] byte_q[$];
    logic [31:0] mon_cyc;
    logic [2:0]  mon_bc;

    usb_rx_timer dut (
        .clk          (clk),
        .rst          (rst),
        .enable_timer (enable_timer),
        .d_edge       (d_edge),
        .stuff_bit    (stuff_bit),
        .shift_enable (shift_enable),
        .byte_received(byte_received),
        .bit_count    (bit_count),
        .rx_error     (rx_error),
        .state_dbg    (state_dbg)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic e, input logic s);
        d_edge    = e;
        stuff_bit = s;
        tick();
        d_edge    = 1'b0;
        stuff_bit = 1'b0;
    endtask

    task automatic push_strobe(input int c, input int bc);
        exp_q.push_back(32'(c));
        exp_bc_q.push_back(3'(bc));
    endtask

    task automatic start_run(input string tag);
        enable_timer = 1'b1;
        tick();
        check({tag, "_enter_run"}, 32'(state_dbg), 32'd1);
    endtask

    task automatic stop_run(input string tag);
        enable_timer = 1'b0;
        tick();
        check({tag, "_state_idle"}, 32'(state_dbg), 32'd0);
        check({tag, "_bit_count_clr"}, 32'(bit_count), 32'd0);
        check({tag, "_rx_error_clr"}, 32'(rx_error), 32'd0);
        check({tag, "_byte_low"}, 32'(byte_received), 32'd0);
        check({tag, "_strobes_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_bytes_left"}, 32'(byte_q.size()), 32'd0);
    endtask

    // Edge every 8 clocks, one full byte; enable drops in the byte_received cycle
    task automatic run_byte(input string tag);
        int t;
        start_run(tag);
        t = cyc;
        for (int k = 0; k < 8; k++) push_strobe(t + 4 + 8 * k, k);
        byte_q.push_back(32'(t + 61));
        for (int i = 0; i <= 60; i++) step(i % 8 == 0, 1'b0);
        check({tag, "_byte_at_t61"}, 32'(byte_received), 32'd1);
        check({tag, "_bit_count_wrap"}, 32'(bit_count), 32'd0);
        check({tag, "_no_error"}, 32'(rx_error), 32'd0);
        stop_run(tag);
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (shift_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe_cycle", 32'(cyc), 32'hffffffff);
            end else begin
                mon_cyc = exp_q.pop_front();
                mon_bc  = exp_bc_q.pop_front();
                check("strobe_cycle", 32'(cyc), mon_cyc);
                check("strobe_bit_count", 32'(bit_count), 32'(mon_bc));
            end
        end
        if (byte_received === 1'b1) begin
            if (byte_q.size() == 0) begin
                check("unexpected_byte_cycle", 32'(cyc), 32'hffffffff);
            end else begin
                mon_cyc = byte_q.pop_front();
                check("byte_cycle", 32'(cyc), mon_cyc);
            end
        end
    end

    initial begin
        int t;
        rst          = 1'b1;
        enable_timer = 1'b1;
        d_edge       = 1'b0;
        stuff_bit    = 1'b0;

        // Reset held with enable and edges active
        tick();
        d_edge = 1'b1;
        tick();
        d_edge = 1'b0;
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_shift_enable", 32'(shift_enable), 32'd0);
        check("rst_byte_received", 32'(byte_received), 32'd0);
        check("rst_bit_count", 32'(bit_count), 32'd0);
        check("rst_rx_error", 32'(rx_error), 32'd0);
        rst = 1'b0;
        start_run("rst_release");
        stop_run("rst_release");

        // Nominal byte
        run_byte("nominal");

        // Early edge resynchronises the sample point
        start_run("resync");
        t = cyc;
        push_strobe(t + 4, 0);
        push_strobe(t + 10, 1);
        for (int i = 0; i <= 13; i++) begin
            if (i == 12) check("resync_no_strobe_t12", 32'(shift_enable), 32'd0);
            step(i == 0 || i == 6, 1'b0);
        end
        check("resync_bit_count", 32'(bit_count), 32'd2);
        stop_run("resync");

        // Stuffed bit skipped at the third sample point
        start_run("stuff");
        t = cyc;
        for (int k = 0; k < 9; k++) begin
            if (k < 2) push_strobe(t + 4 + 8 * k, k);
            else if (k > 2) push_strobe(t + 4 + 8 * k, k - 1);
        end
        byte_q.push_back(32'(t + 69));
        for (int i = 0; i <= 71; i++) begin
            if (i == 21) check("stuff_bit_count_stall", 32'(bit_count), 32'd2);
            step(i % 8 == 0, i == 20);
        end
        stop_run("stuff");

        // Dead line after a single edge
        start_run("idle");
        t = cyc;
        for (int k = 0; k < 8; k++) push_strobe(t + 4 + 8 * k, k);
        byte_q.push_back(32'(t + 61));
        step(1'b1, 1'b0);
        for (int i = 1; i <= 62; i++) begin
            if (i == 57) check("idle_rx_error_t57", 32'(rx_error), 32'd0);
            if (i == 58 || i == 62) check("idle_rx_error_set", 32'(rx_error), 32'd1);
            step(1'b0, 1'b0);
        end
        stop_run("idle");

        // Enable dropped mid-byte, then a fresh byte
        start_run("abort");
        t = cyc;
        for (int k = 0; k < 5; k++) push_strobe(t + 4 + 8 * k, k);
        for (int i = 0; i <= 37; i++) step(i % 8 == 0, 1'b0);
        check("abort_bit_count5", 32'(bit_count), 32'd5);
        stop_run("abort");
        run_byte("refill");

        // Edge coincident with the sample point
        start_run("coincide");
        t = cyc;
        push_strobe(t + 4, 0);
        push_strobe(t + 8, 1);
        for (int i = 0; i <= 8; i++) step(i == 0 || i == 4, 1'b0);
        check("coincide_bit_count", 32'(bit_count), 32'd2);
        stop_run("coincide");

        // Reset in the middle of a byte
        start_run("midrst");
        t = cyc;
        push_strobe(t + 4, 0);
        push_strobe(t + 12, 1);
        for (int i = 0; i <= 17; i++) step(i % 8 == 0, 1'b0);
        rst = 1'b1;
        tick();
        check("midrst_state", 32'(state_dbg), 32'd0);
        check("midrst_bit_count", 32'(bit_count), 32'd0);
        rst          = 1'b0;
        enable_timer = 1'b0;
        tick();
        check("midrst_stay_idle", 32'(state_dbg), 32'd0);
        check("final_strobes_left", 32'(exp_q.size()), 32'd0);
        check("final_bytes_left", 32'(byte_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
